instr_fetch: RTL

Fetch stage between the processor core and the synchronous instruction memory. It owns the program counter and drives address_imem. It pairs each q_imem word with the PC that produced it, absorbing the imem's one-cycle read latency. It supports stall (hold the current instruction) and redirect (branch/jump target, zero-bubble), and counts consumed instructions for performance tracking.

---
 rtl/instr_fetch.sv | 71 +++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the synchronous imem and pairs each returned
// word with its address. It supports stall-hold, zero-bubble redirect and a consumed-instruction count.
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 12,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] address_imem,
  input  logic [DATA_W-1:0] q_imem,
  output logic              insn_valid,
  output logic [DATA_W-1:0] insn,
  output logic [ADDR_W-1:0] insn_pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic [31:0]       fetch_count
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] resp_pc;
  logic              resp_valid;
  logic [31:0]       count_q;
  logic              hold;
  logic              consumed;

  assign hold     = stall & resp_valid & ~redirect_valid;
  assign consumed = resp_valid & ~stall;

  // While holding, the same word is re-read so q_imem stays stable.
  always_comb begin
    if (!reset)
      address_imem = RESET_PC;
    else if (redirect_valid)
      address_imem = redirect_pc;
    else if (hold)
      address_imem = resp_pc;
    else
      address_imem = pc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      resp_pc    <= '0;
      resp_valid <= 1'b0;
      count_q    <= '0;
    end else begin
      if (consumed)
        count_q <= count_q + 32'd1;
      if (redirect_valid) begin
        resp_pc    <= redirect_pc;
        resp_valid <= 1'b1;
        pc         <= redirect_pc + 1'b1;
      end else if (!hold) begin
        resp_pc    <= pc;
        resp_valid <= 1'b1;
        pc         <= pc + 1'b1;
      end
    end
  end

  assign insn_valid  = resp_valid;
  assign insn        = q_imem;
  assign insn_pc     = resp_pc;
  assign pc_plus1    = resp_pc + 1'b1;
  assign fetch_count = count_q;

endmodule
